// File: rtl/reg_bank_param_if.sv
// Register bank bus: read/write/claim requests from decode+writeback, read data and hazard flags back.
// Latency: carries no state of its own; timing is set by the bank behind the slave modport.
// Backpressure: none; every field is sampled by the bank every cycle.
//
// Ports (master = decode/writeback side, slave = register bank):
//   rs1, rs2, rd, write_data, reg_write, claim_en, claim_rd  master -> slave
//   data1, data2, dbg_out, rs1_busy, rs2_busy                 slave  -> master
interface reg_bank_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
  logic              claim_en;
  logic [ADDR_W-1:0] claim_rd;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] dbg_out;
  logic              rs1_busy;
  logic              rs2_busy;

  modport master (
    output rs1, rs2, rd, write_data, reg_write, claim_en, claim_rd,
    input  data1, data2, dbg_out, rs1_busy, rs2_busy
  );

  modport slave (
    input  rs1, rs2, rd, write_data, reg_write, claim_en, claim_rd,
    output data1, data2, dbg_out, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/reg_bank_param.sv
// Parametrised register file: 2 registered read ports with write bypass, 1 write port, pending-write scoreboard.
// Latency: reads, writes and debug copy take 1 edge; busy flags are combinational in the same cycle.
// Backpressure: none; every input is consumed every cycle.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    reg_bank_param_if.slave (read addresses, write port, claim port, read data, busy flags)
module reg_bank_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int PROT_REG = 15,
  parameter int DBG_REG  = 13
) (
  input logic             clk,
  input logic             rst_n,
  reg_bank_param_if.slave bus
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] PROT_A = ADDR_W'(PROT_REG);
  localparam logic [ADDR_W-1:0] DBG_A  = ADDR_W'(DBG_REG);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pending;
  logic [NREGS-1:0]  pending_nxt;

  logic              wr_eff;
  logic              claim_ok;
  logic [DATA_W-1:0] rd1_nxt;
  logic [DATA_W-1:0] rd2_nxt;
  logic [DATA_W-1:0] dbg_nxt;
  logic [DATA_W-1:0] data1_q;
  logic [DATA_W-1:0] data2_q;
  logic [DATA_W-1:0] dbg_q;

  // Boot constants live in registers 2 and 3; everything else starts at zero.
  function automatic logic [DATA_W-1:0] reset_val(input int idx);
    if (idx == 2)      return DATA_W'(2);
    else if (idx == 3) return DATA_W'(349);
    else               return '0;
  endfunction

  // Read priority: hardwired zero, then same-cycle write bypass, then storage.
  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wr,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (addr == ZERO_A)           return '0;
    else if (wr && waddr == addr) return wdata;
    else                          return stored;
  endfunction

  assign wr_eff   = bus.reg_write && (bus.rd != ZERO_A) && (bus.rd != PROT_A);
  assign claim_ok = bus.claim_en && (bus.claim_rd != ZERO_A) && (bus.claim_rd != PROT_A);

  always_comb begin
    rd1_nxt = read_sel(bus.rs1, regs[bus.rs1], wr_eff, bus.rd, bus.write_data);
    rd2_nxt = read_sel(bus.rs2, regs[bus.rs2], wr_eff, bus.rd, bus.write_data);
    dbg_nxt = read_sel(DBG_A,   regs[DBG_A],   wr_eff, bus.rd, bus.write_data);
  end

  // Claim is applied after the clear so a same-register claim keeps the bit set.
  always_comb begin
    pending_nxt = pending;
    if (wr_eff)   pending_nxt[bus.rd]       = 1'b0;
    if (claim_ok) pending_nxt[bus.claim_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= reset_val(i);
    end else if (wr_eff) begin
      regs[bus.rd] <= bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      data1_q <= '0;
      data2_q <= '0;
      dbg_q   <= '0;
    end else begin
      pending <= pending_nxt;
      data1_q <= rd1_nxt;
      data2_q <= rd2_nxt;
      dbg_q   <= dbg_nxt;
    end
  end

  assign bus.data1   = data1_q;
  assign bus.data2   = data2_q;
  assign bus.dbg_out = dbg_q;

  // Zero and protected registers can never be pending, so they never report busy.
  assign bus.rs1_busy = pending[bus.rs1] & ~(wr_eff && (bus.rd == bus.rs1));
  assign bus.rs2_busy = pending[bus.rs2] & ~(wr_eff && (bus.rd == bus.rs2));

endmodule

// File: tb/tb_reg_bank_param.sv
// Bench for reg_bank_param: directed vector table, reset sequences, then random traffic vs a reference model.
// Latency: inputs driven on the falling edge, busy sampled 1 ns later, read data sampled on the next falling edge.
// Backpressure: none; one request per cycle.
module tb_reg_bank_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_bank_param_if #(.DATA_W(32), .ADDR_W(4)) bif ();

  reg_bank_param #(
    .DATA_W(32), .ADDR_W(4), .ZERO_REG(0), .PROT_REG(15), .DBG_REG(13)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: architectural register contents and outstanding writers.
  logic [31:0] m_regs [16];
  bit          m_pend [16];

  typedef struct {
    logic [3:0]  rs1, rs2, rd;
    logic [31:0] wd;
    logic        we, ce;
    logic [3:0]  cr;
    logic [31:0] e1, e2;
    logic        eb1, eb2;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit m_eff(input logic we, input logic [3:0] d);
    return we && d != 4'd0 && d != 4'd15;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a, input logic we,
                                         input logic [3:0] d, input logic [31:0] wd);
    if (a == 4'd0) return 32'd0;
    if (m_eff(we, d) && d == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [3:0] a, input logic we, input logic [3:0] d);
    return m_pend[a] && !(m_eff(we, d) && d == a);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 1'b0;
    end
    m_regs[2] = 32'd2;
    m_regs[3] = 32'd349;
  endtask

  task automatic m_edge(input logic we, input logic [3:0] d, input logic [31:0] wd,
                        input logic ce, input logic [3:0] cr);
    if (m_eff(we, d)) begin
      m_regs[d] = wd;
      m_pend[d] = 1'b0;
    end
    if (ce && cr != 4'd0 && cr != 4'd15) m_pend[cr] = 1'b1;
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic run_cycle(input string tag,
                           input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] d,
                           input logic [31:0] wd, input logic we, input logic ce,
                           input logic [3:0] cr,
                           input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] edbg,
                           input logic eb1, input logic eb2);
    bif.rs1 = a1; bif.rs2 = a2; bif.rd = d; bif.write_data = wd;
    bif.reg_write = we; bif.claim_en = ce; bif.claim_rd = cr;
    #1;
    chk({tag, ".rs1_busy"}, 32'(bif.rs1_busy), 32'(eb1));
    chk({tag, ".rs2_busy"}, 32'(bif.rs2_busy), 32'(eb2));
    @(posedge clk);
    m_edge(we, d, wd, ce, cr);
    @(negedge clk);
    chk({tag, ".data1"},   bif.data1,   e1);
    chk({tag, ".data2"},   bif.data2,   e2);
    chk({tag, ".dbg_out"}, bif.dbg_out, edbg);
  endtask

  initial begin
    vecs[0]  = '{4'd2,  4'd3,  4'd0,  32'h0,        1'b0, 1'b0, 4'd0,  32'd2,        32'd349,      1'b0, 1'b0};
    vecs[1]  = '{4'd5,  4'd0,  4'd5,  32'hDEADBEEF, 1'b1, 1'b0, 4'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{4'd0,  4'd5,  4'd0,  32'h7,        1'b1, 1'b0, 4'd0,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vecs[3]  = '{4'd0,  4'd0,  4'd0,  32'h0,        1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        1'b0, 1'b0};
    vecs[4]  = '{4'd15, 4'd2,  4'd15, 32'h9,        1'b1, 1'b0, 4'd0,  32'h0,        32'd2,        1'b0, 1'b0};
    vecs[5]  = '{4'd15, 4'd15, 4'd0,  32'h0,        1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        1'b0, 1'b0};
    vecs[6]  = '{4'd0,  4'd0,  4'd0,  32'h0,        1'b0, 1'b1, 4'd0,  32'h0,        32'h0,        1'b0, 1'b0};
    vecs[7]  = '{4'd0,  4'd15, 4'd0,  32'h0,        1'b0, 1'b1, 4'd15, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[8]  = '{4'd6,  4'd0,  4'd0,  32'h0,        1'b0, 1'b1, 4'd6,  32'h0,        32'h0,        1'b0, 1'b0};
    vecs[9]  = '{4'd6,  4'd6,  4'd0,  32'h0,        1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        1'b1, 1'b1};
    vecs[10] = '{4'd6,  4'd6,  4'd6,  32'h11,       1'b1, 1'b0, 4'd0,  32'h11,       32'h11,       1'b0, 1'b0};
    vecs[11] = '{4'd6,  4'd0,  4'd0,  32'h0,        1'b0, 1'b0, 4'd0,  32'h11,       32'h0,        1'b0, 1'b0};
    vecs[12] = '{4'd6,  4'd0,  4'd6,  32'h11,       1'b1, 1'b1, 4'd6,  32'h11,       32'h0,        1'b0, 1'b0};
    vecs[13] = '{4'd6,  4'd6,  4'd0,  32'h0,        1'b0, 1'b0, 4'd0,  32'h11,       32'h11,       1'b1, 1'b1};
    vecs[14] = '{4'd6,  4'd0,  4'd6,  32'h33,       1'b1, 1'b0, 4'd0,  32'h33,       32'h0,        1'b0, 1'b0};
    vecs[15] = '{4'd13, 4'd13, 4'd13, 32'h1234,     1'b1, 1'b0, 4'd0,  32'h1234,     32'h1234,     1'b0, 1'b0};

    // Reset held with reset-release stimulus already on the bus.
    rst_n = 1'b0;
    bif.rs1 = 4'd2; bif.rs2 = 4'd3; bif.rd = 4'd0; bif.write_data = 32'h0;
    bif.reg_write = 1'b0; bif.claim_en = 1'b0; bif.claim_rd = 4'd0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset.data1",    bif.data1,   32'h0);
    chk("reset.data2",    bif.data2,   32'h0);
    chk("reset.dbg_out",  bif.dbg_out, 32'h0);
    chk("reset.rs1_busy", 32'(bif.rs1_busy), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_cycle($sformatf("vec%0d", i), vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wd,
                vecs[i].we, vecs[i].ce, vecs[i].cr, vecs[i].e1, vecs[i].e2,
                m_read(4'd13, vecs[i].we, vecs[i].rd, vecs[i].wd), vecs[i].eb1, vecs[i].eb2);
    end

    // Mid-operation reset: outputs clear without a clock; in-flight write and claim are dropped.
    run_cycle("pre_rst", 4'd5, 4'd6, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0,
              32'hDEADBEEF, 32'h33, 32'h1234, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst.data1",   bif.data1,   32'h0);
    chk("midrst.data2",   bif.data2,   32'h0);
    chk("midrst.dbg_out", bif.dbg_out, 32'h0);
    bif.reg_write = 1'b1; bif.rd = 4'd5; bif.write_data = 32'hAAAA5555;
    bif.claim_en = 1'b1; bif.claim_rd = 4'd7;
    @(posedge clk);
    @(negedge clk);
    m_reset();
    rst_n = 1'b1;
    run_cycle("post_rst", 4'd7, 4'd5, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0,
              32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    run_cycle("post_rst2", 4'd2, 4'd3, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0,
              32'd2, 32'd349, 32'h0, 1'b0, 1'b0);

    // Random traffic, biased toward read/write/claim address collisions.
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  a1, a2, d, cr;
      logic [31:0] wd;
      logic        we, ce;
      d  = 4'($urandom_range(0, 15));
      cr = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
      a2 = ($urandom_range(0, 3) == 0) ? cr : 4'($urandom_range(0, 15));
      wd = $urandom;
      we = 1'($urandom_range(0, 1));
      ce = ($urandom_range(0, 2) == 0);
      run_cycle($sformatf("rnd%0d", i), a1, a2, d, wd, we, ce, cr,
                m_read(a1, we, d, wd), m_read(a2, we, d, wd), m_read(4'd13, we, d, wd),
                m_busy(a1, we, d), m_busy(a2, we, d));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
